k_and_s_control_unit: RTL

- Multi-cycle control FSM for the K&S processor: the opposite end of the datapath control/status interface.
- Consumes `decoded_instruction` and the four registered ALU flags from the datapath.
- Drives every datapath enable/select, the RAM write strobe and a halt indication.
- Sits beside the datapath under the processor top; memory read is asynchronous (data_in valid in the same cycle as ram_addr), optionally padded with wait cycles.

---
 rtl/k_and_s_control_unit.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/k_and_s_control_unit.sv
// K&S processor control unit: multi-cycle Moore FSM driving the datapath
// enables/selects, RAM write strobe, halt indication and a retired-instruction counter.

package k_and_s_pkg;
  typedef enum logic [3:0] {
    I_NOP    = 4'd0,
    I_LOAD   = 4'd1,
    I_STORE  = 4'd2,
    I_MOVE   = 4'd3,
    I_ADD    = 4'd4,
    I_SUB    = 4'd5,
    I_AND    = 4'd6,
    I_OR     = 4'd7,
    I_BRANCH = 4'd8,
    I_BZERO  = 4'd9,
    I_BNEG   = 4'd10,
    I_BNNEG  = 4'd11,
    I_BOV    = 4'd12,
    I_BNOV   = 4'd13,
    I_HALT   = 4'd14
  } decoded_instruction_type;
endpackage

module k_and_s_control_unit
  import k_and_s_pkg::*;
#(
  parameter int MEM_WAIT_CYCLES = 0,
  parameter int RETIRE_CNT_W    = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  decoded_instruction_type       decoded_instruction,
  input  logic                          zero_op,
  input  logic                          neg_op,
  input  logic                          unsigned_overflow,
  input  logic                          signed_overflow,
  output logic                          branch,
  output logic                          pc_enable,
  output logic                          ir_enable,
  output logic                          addr_sel,
  output logic                          c_sel,
  output logic [1:0]                    operation,
  output logic                          write_reg_enable,
  output logic                          flags_reg_enable,
  output logic                          ram_write_enable,
  output logic                          halt,
  output logic [RETIRE_CNT_W-1:0]       retired_count
);

  typedef enum logic [2:0] {
    S_FETCH    = 3'd0,
    S_DECODE   = 3'd1,
    S_EXEC_ALU = 3'd2,
    S_LOAD     = 3'd3,
    S_STORE    = 3'd4,
    S_BR_TAKEN = 3'd5,
    S_HALTED   = 3'd6
  } state_t;

  localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT_CYCLES);
  localparam logic [RETIRE_CNT_W-1:0] RETIRE_MAX = {RETIRE_CNT_W{1'b1}};

  state_t     state_r, next_state_s, eff_state_s;
  logic [2:0] wait_r, next_wait_s, eff_wait_s;
  logic       started_r;
  logic       retire_s, eff_retire_s, taken_s, wait_last_s;
  logic       branch_s, pc_enable_s, ir_enable_s, addr_sel_s, c_sel_s;
  logic [1:0] operation_s;
  logic       write_reg_enable_s, flags_reg_enable_s, ram_write_enable_s, halt_s;
  // Unsigned overflow is part of the flag interface but never steers control flow.
  logic       unused_flag_s;

  assign unused_flag_s = unsigned_overflow;
  assign wait_last_s   = (wait_r == WAIT_LAST);

  // Conditional branch resolution from the flags present during DECODE.
  always_comb begin
    taken_s = 1'b0;
    case (decoded_instruction)
      I_BZERO: taken_s = zero_op;
      I_BNEG:  taken_s = neg_op;
      I_BNNEG: taken_s = ~neg_op;
      I_BOV:   taken_s = signed_overflow;
      I_BNOV:  taken_s = ~signed_overflow;
      default: taken_s = 1'b0;
    endcase
  end

  // Next-state, wait-counter and retire decision.
  always_comb begin
    next_state_s = state_r;
    next_wait_s  = 3'd0;
    retire_s     = 1'b0;
    case (state_r)
      S_FETCH: begin
        if (wait_last_s) begin
          next_state_s = S_DECODE;
        end else begin
          next_wait_s = wait_r + 3'd1;
        end
      end
      S_DECODE: begin
        case (decoded_instruction)
          I_ADD, I_SUB, I_AND, I_OR, I_MOVE: next_state_s = S_EXEC_ALU;
          I_LOAD:   next_state_s = S_LOAD;
          I_STORE:  next_state_s = S_STORE;
          I_BRANCH: next_state_s = S_BR_TAKEN;
          I_BZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV: begin
            if (taken_s) begin
              next_state_s = S_BR_TAKEN;
            end else begin
              next_state_s = S_FETCH;
              retire_s     = 1'b1;
            end
          end
          I_HALT: begin
            next_state_s = S_HALTED;
            retire_s     = 1'b1;
          end
          default: begin
            next_state_s = S_FETCH;
            retire_s     = 1'b1;
          end
        endcase
      end
      S_LOAD: begin
        if (wait_last_s) begin
          next_state_s = S_FETCH;
          retire_s     = 1'b1;
        end else begin
          next_wait_s = wait_r + 3'd1;
        end
      end
      S_EXEC_ALU, S_STORE, S_BR_TAKEN: begin
        next_state_s = S_FETCH;
        retire_s     = 1'b1;
      end
      S_HALTED: next_state_s = S_HALTED;
      default:  next_state_s = S_FETCH;
    endcase
  end

  // The first edge after reset release parks the FSM at the start of FETCH.
  always_comb begin
    if (started_r) begin
      eff_state_s  = next_state_s;
      eff_wait_s   = next_wait_s;
      eff_retire_s = retire_s;
    end else begin
      eff_state_s  = S_FETCH;
      eff_wait_s   = 3'd0;
      eff_retire_s = 1'b0;
    end
  end

  // Moore outputs for the state being entered; registered alongside the state.
  always_comb begin
    branch_s           = 1'b0;
    pc_enable_s        = 1'b0;
    ir_enable_s        = 1'b0;
    addr_sel_s         = 1'b0;
    c_sel_s            = 1'b0;
    operation_s        = 2'b00;
    write_reg_enable_s = 1'b0;
    flags_reg_enable_s = 1'b0;
    ram_write_enable_s = 1'b0;
    halt_s             = 1'b0;
    case (eff_state_s)
      S_FETCH: begin
        ir_enable_s = (eff_wait_s == WAIT_LAST);
        pc_enable_s = (eff_wait_s == WAIT_LAST);
      end
      S_EXEC_ALU: begin
        write_reg_enable_s = 1'b1;
        flags_reg_enable_s = 1'b1;
        case (decoded_instruction)
          I_ADD:   operation_s = 2'b00;
          I_AND:   operation_s = 2'b01;
          I_OR:    operation_s = 2'b10;
          I_SUB:   operation_s = 2'b11;
          I_MOVE:  operation_s = 2'b10;
          default: operation_s = 2'b00;
        endcase
      end
      S_LOAD: begin
        addr_sel_s         = 1'b1;
        c_sel_s            = (eff_wait_s == WAIT_LAST);
        write_reg_enable_s = (eff_wait_s == WAIT_LAST);
      end
      S_STORE: begin
        addr_sel_s         = 1'b1;
        ram_write_enable_s = 1'b1;
      end
      S_BR_TAKEN: begin
        pc_enable_s = 1'b1;
        branch_s    = 1'b1;
      end
      S_HALTED: halt_s = 1'b1;
      default:  halt_s = 1'b0;
    endcase
  end

  // State, wait counter, registered outputs and saturating retire counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r          <= S_FETCH;
      wait_r           <= 3'd0;
      started_r        <= 1'b0;
      branch           <= 1'b0;
      pc_enable        <= 1'b0;
      ir_enable        <= 1'b0;
      addr_sel         <= 1'b0;
      c_sel            <= 1'b0;
      operation        <= 2'b00;
      write_reg_enable <= 1'b0;
      flags_reg_enable <= 1'b0;
      ram_write_enable <= 1'b0;
      halt             <= 1'b0;
      retired_count    <= '0;
    end else begin
      state_r          <= eff_state_s;
      wait_r           <= eff_wait_s;
      started_r        <= 1'b1;
      branch           <= branch_s;
      pc_enable        <= pc_enable_s;
      ir_enable        <= ir_enable_s;
      addr_sel         <= addr_sel_s;
      c_sel            <= c_sel_s;
      operation        <= operation_s;
      write_reg_enable <= write_reg_enable_s;
      flags_reg_enable <= flags_reg_enable_s;
      ram_write_enable <= ram_write_enable_s;
      halt             <= halt_s;
      if (eff_retire_s && (retired_count != RETIRE_MAX)) begin
        retired_count <= retired_count + RETIRE_CNT_W'(1);
      end else begin
        retired_count <= retired_count;
      end
    end
  end

endmodule
